// File: rtl/inst_sram_resp_pkg.sv
// inst_sram_resp_pkg: shared constants and types for the instruction SRAM responder.
//   INST_SRAM_BASE : byte address of instruction SRAM word 0
//   LA_NOP         : LoongArch NOP (andi r0,r0,0), used as the fill pattern
//   state_e        : responder FSM states
package inst_sram_resp_pkg;

    localparam logic [31:0] INST_SRAM_BASE = 32'h1c00_0000;
    localparam logic [31:0] LA_NOP         = 32'h0340_0000;

    typedef enum logic {
        ST_INIT,
        ST_READY
    } state_e;

endpackage

// File: rtl/sram_sp_bytewe.sv
// sram_sp_bytewe: generic single-port RAM with per-byte write enables.
// Reads are registered; the output holds while en is low or a write is in
// progress (no-change mode), so rdata_o only ever moves on a read.
//   clk     : clock
//   en_i    : access enable
//   we_i    : byte write enables, 4'h0 = read
//   addr_i  : word index
//   wdata_i : write data
//   rdata_o : registered read data
module sram_sp_bytewe #(
    parameter int DEPTH = 4096,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          en_i,
    input  logic [3:0]    we_i,
    input  logic [AW-1:0] addr_i,
    input  logic [31:0]   wdata_i,
    output logic [31:0]   rdata_o
);

    logic [31:0] mem [DEPTH];
    logic [31:0] rdata_q;

    always_ff @(posedge clk) begin
        if (en_i) begin
            if (we_i == 4'h0) begin
                rdata_q <= mem[addr_i];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (we_i[b]) mem[addr_i][8*b +: 8] <= wdata_i[8*b +: 8];
                end
            end
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/inst_sram_resp.sv
// inst_sram_resp: instruction SRAM slave for the fetch stage.
// After reset every word is filled with FILL_WORD; afterwards reads return
// one cycle after the request and writes are byte-masked. Range and
// alignment violations raise sticky flags.
//   clk, reset      : clock, synchronous active-high reset
//   inst_sram_en    : request valid
//   inst_sram_we    : byte write enables, 4'h0 = read
//   inst_sram_addr  : byte address
//   inst_sram_wdata : write data
//   inst_sram_rdata : read data, held until the next read
//   init_done       : fill sequence complete
//   err_range       : sticky, access outside the SRAM window
//   err_align       : sticky, access with addr[1:0] != 0
module inst_sram_resp
    import inst_sram_resp_pkg::*;
#(
    parameter logic [31:0] ADDR_BASE   = INST_SRAM_BASE,
    parameter int          DEPTH_WORDS = 4096,
    parameter logic [31:0] FILL_WORD   = LA_NOP,
    parameter int          IDX_W       = $clog2(DEPTH_WORDS)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        inst_sram_en,
    input  logic [3:0]  inst_sram_we,
    input  logic [31:0] inst_sram_addr,
    input  logic [31:0] inst_sram_wdata,
    output logic [31:0] inst_sram_rdata,
    output logic        init_done,
    output logic        err_range,
    output logic        err_align
);

    localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) << 2;

    state_e           state_q;
    logic [IDX_W-1:0] cnt_q;
    logic             init_done_q;
    logic             err_range_q;
    logic             err_align_q;
    // Masks the RAM output with zero: after reset and after an out-of-range read.
    logic             rd_zero_q;

    logic [31:0]      offset;
    logic             in_range;
    logic             filling;
    logic             ram_en;
    logic [3:0]       ram_we;
    logic [IDX_W-1:0] ram_addr;
    logic [31:0]      ram_wdata;
    logic [31:0]      ram_rdata;

    // Subtraction wraps, so addresses below the base land far above SPAN.
    assign offset   = inst_sram_addr - ADDR_BASE;
    assign in_range = {1'b0, offset} < SPAN;
    assign filling  = (state_q == ST_INIT);

    always_comb begin
        ram_en    = 1'b0;
        ram_we    = 4'h0;
        ram_addr  = offset[IDX_W+1:2];
        ram_wdata = inst_sram_wdata;
        if (filling) begin
            ram_en    = 1'b1;
            ram_we    = 4'hf;
            ram_addr  = cnt_q;
            ram_wdata = FILL_WORD;
        end else if (inst_sram_en && in_range) begin
            ram_en    = 1'b1;
            ram_we    = inst_sram_we;
        end
    end

    sram_sp_bytewe #(
        .DEPTH (DEPTH_WORDS),
        .AW    (IDX_W)
    ) u_ram (
        .clk     (clk),
        .en_i    (ram_en),
        .we_i    (ram_we),
        .addr_i  (ram_addr),
        .wdata_i (ram_wdata),
        .rdata_o (ram_rdata)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_INIT;
            cnt_q       <= '0;
            init_done_q <= 1'b0;
            err_range_q <= 1'b0;
            err_align_q <= 1'b0;
            rd_zero_q   <= 1'b1;
        end else begin
            case (state_q)
                ST_INIT: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == IDX_W'(DEPTH_WORDS - 1)) state_q <= ST_READY;
                end
                ST_READY: begin
                    init_done_q <= 1'b1;
                    if (inst_sram_en) begin
                        if (!in_range)                 err_range_q <= 1'b1;
                        if (inst_sram_addr[1:0] != 2'b0) err_align_q <= 1'b1;
                        if (inst_sram_we == 4'h0)      rd_zero_q   <= !in_range;
                    end
                end
                default: state_q <= ST_INIT;
            endcase
        end
    end

    assign inst_sram_rdata = rd_zero_q ? 32'h0 : ram_rdata;
    assign init_done       = init_done_q;
    assign err_range       = err_range_q;
    assign err_align       = err_align_q;

endmodule

// File: tb/tb_inst_sram_resp.sv
module tb_inst_sram_resp;

    localparam int DEPTH = 4096;

    logic        clk = 1'b0;
    logic        reset;
    logic        en;
    logic [3:0]  we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        init_done;
    logic        err_range;
    logic        err_align;

    int nchk  = 0;
    int npass = 0;

    always #5 clk = ~clk;

    inst_sram_resp dut (
        .clk             (clk),
        .reset           (reset),
        .inst_sram_en    (en),
        .inst_sram_we    (we),
        .inst_sram_addr  (addr),
        .inst_sram_wdata (wdata),
        .inst_sram_rdata (rdata),
        .init_done       (init_done),
        .err_range       (err_range),
        .err_align       (err_align)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nchk++;
        if (got === exp) npass++;
        else $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    endtask

    // One clock; inputs change and outputs are sampled 1 time unit after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [31:0] a);
        en = 1'b1; we = 4'h0; addr = a; wdata = 32'h0;
        step();
        en = 1'b0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [3:0] m, input logic [31:0] d);
        en = 1'b1; we = m; addr = a; wdata = d;
        step();
        en = 1'b0; we = 4'h0;
    endtask

    task automatic wait_init(input string tag);
        int zeros = 0;
        while (!init_done && zeros < DEPTH + 20) begin
            step();
            if (!init_done) zeros++;
        end
        chk(tag, 32'(zeros), 32'(DEPTH));
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; we = 4'h0; addr = 32'h0; wdata = 32'h0;
        repeat (3) step();
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_done", {31'b0, init_done}, 32'h0);
        chk("rst_flags", {30'b0, err_range, err_align}, 32'h0);

        // Release, then issue bad requests during INIT: all must be ignored.
        reset = 1'b0;
        en = 1'b1; we = 4'h0; addr = 32'h1bff_fffe;
        repeat (100) step();
        chk("init_req_rdata", rdata, 32'h0);
        chk("init_req_flags", {30'b0, err_range, err_align}, 32'h0);
        chk("init_done_mid", {31'b0, init_done}, 32'h0);

        // Reset at fill cycle 100 restarts the fill.
        en = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        wait_init("init_len");
        chk("ready_flags", {30'b0, err_range, err_align}, 32'h0);

        rd(32'h1c00_0000);
        chk("fill_w0", rdata, 32'h0340_0000);
        rd(32'h1c00_3ffc);
        chk("fill_last", rdata, 32'h0340_0000);

        wr(32'h1c00_0010, 4'hf, 32'hdead_beef);
        chk("wr_hold", rdata, 32'h0340_0000);
        wr(32'h1c00_0010, 4'h1, 32'h0000_00aa);
        rd(32'h1c00_0010);
        chk("byte_merge", rdata, 32'hdead_beaa);
        step();
        chk("idle_hold", rdata, 32'hdead_beaa);

        wr(32'h1c00_0020, 4'h6, 32'h1122_3344);
        rd(32'h1c00_0020);
        chk("mid_bytes", rdata, 32'h0322_3300);

        for (int i = 0; i < 8; i++) wr(32'h1c00_0000 + 32'(4 * i), 4'hf, 32'hc0de_0000 + 32'(i));
        en = 1'b1; we = 4'h0;
        for (int i = 0; i < 8; i++) begin
            addr = 32'h1c00_0000 + 32'(4 * i);
            step();
            chk($sformatf("stream%0d", i), rdata, 32'hc0de_0000 + 32'(i));
        end
        en = 1'b0;
        chk("no_flags", {30'b0, err_range, err_align}, 32'h0);

        rd(32'h1bff_fffc);
        chk("below_rdata", rdata, 32'h0);
        chk("below_flags", {30'b0, err_range, err_align}, 32'h2);
        rd(32'h1c00_0002);
        chk("misalign_data", rdata, 32'hc0de_0000);
        chk("misalign_flags", {30'b0, err_range, err_align}, 32'h3);
        rd(32'h1c00_0004);
        wr(32'h1c00_4000, 4'hf, 32'h1234_5678);
        chk("oor_wr_hold", rdata, 32'hc0de_0001);
        rd(32'h1c00_4000);
        chk("above_rdata", rdata, 32'h0);
        repeat (3) step();
        chk("sticky", {30'b0, err_range, err_align}, 32'h3);

        reset = 1'b1;
        step();
        chk("rerst_flags", {30'b0, err_range, err_align}, 32'h0);
        chk("rerst_rdata", rdata, 32'h0);
        reset = 1'b0;
        wait_init("init_len2");
        rd(32'h1c00_0010);
        chk("refill", rdata, 32'h0340_0000);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
